stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
- Pipeline interlock scheduler for the 5-stage MIPS core.
- Decides each cycle whether IF/ID hold, whether a bubble goes into EX, and whether the whole pipe freezes for a slow data memory.
- Its bubble_ex output drives the stall input of the EX-stage control decoder; that decoder clears its registered Op/funct/rt/rd on the next clk edge.
- Also tracks memory-wait timeout and keeps stall performance counters.

Parameters:
MEM_TIMEOUT, 64, consecutive frozen cycles before mem_err is raised (range 2..65535)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
rstn  in  1  reset; asynchronous, active-low
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_is_branch  in  1  ID instruction resolves in ID (beq/bne/blez/bgtz/bltz/bgez/jr/jalr)
ex_rfwr  in  1  EX instruction writes the register file
ex_wbsel  in  5  EX destination register
ex_is_load  in  1  EX instruction is lb/lh/lbu/lhu/lw
mem_rfwr  in  1  MEM instruction writes the register file
mem_wbsel  in  5  MEM destination register
mem_is_load  in  1  MEM instruction is a load
mem_req  in  1  data memory access active this cycle
mem_ready  in  1  data memory completes this cycle
perf_clr  in  1  synchronous clear of performance counters
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
bubble_ex  out  1  insert NOP into EX (drives decoder stall)
freeze  out  1  hold every pipeline register, including EX/MEM/WB
mem_err  out  1  sticky memory-timeout flag
hz_cnt  out  CNT_W  cycles with bubble_ex=1
frz_cnt  out  CNT_W  cycles with freeze=1

Behaviour:
- match(r) = r!=0 && ((id_use_rs && id_rs==r) || (id_use_rt && id_rt==r)). Register $0 never causes a hazard.
- Hazard conditions:
  - H1, load-use: ex_is_load && ex_rfwr && match(ex_wbsel).
  - H2, branch on EX result: id_is_branch && ex_rfwr && match(ex_wbsel).
  - H3, branch on MEM load: id_is_branch && mem_is_load && mem_rfwr && match(mem_wbsel).
- hazard = H1|H2|H3, evaluated combinationally from current inputs.
- A branch that depends on a load in EX stalls 2 cycles: H1/H2 in the first cycle, H3 in the second. No extra state is needed for this.
- Memory FSM states: IDLE, WAIT, ERR.
  - IDLE→WAIT: mem_req && !mem_ready.
  - WAIT→IDLE: mem_ready.
  - WAIT→ERR: wait_cnt reaches MEM_TIMEOUT-1 while still !mem_ready.
  - ERR is left only by reset.
- wait_cnt: 16-bit counter. Cleared in IDLE, incremented each WAIT cycle.
- freeze = (mem_req && !mem_ready) in IDLE or WAIT, or state==ERR. It asserts in the same cycle the slow access starts.
- Output priority:
  - freeze=1 forces bubble_ex=0. stall_if and stall_id follow freeze in that case.
  - Otherwise stall_if = stall_id = bubble_ex = hazard.
  - A hazard pending during freeze is re-evaluated once freeze drops.
- mem_err = (state==ERR). It is sticky.
- Counters: increment on bubble_ex / freeze respectively, saturating at all-ones. perf_clr zeroes both next edge and wins over increment.
- Reset (rstn=0, asynchronous): state=IDLE, wait_cnt=0, hz_cnt=0, frz_cnt=0, mem_err=0.
- While in reset, all combinational stall outputs are forced to 0.
- Reset during WAIT or ERR returns to IDLE immediately.
- Simultaneous mem_req && mem_ready in IDLE: no freeze, state stays IDLE.

Decomposition:
- Shared constants header alongside the existing opcode/funct definitions: FSM state encodings (STALL_IDLE=2'd0, STALL_WAIT=2'd1, STALL_ERR=2'd2) and the MEM_TIMEOUT default.
- One natural sub-module: mem_wait_fsm. It contains the FSM and wait_cnt, and outputs freeze_req and mem_err.
- Hazard compare and counters stay in stall_ctrl.

Test Plan:
1. Load-use: ex_is_load=1, ex_rfwr=1, ex_wbsel=8, id_rs=8, id_use_rs=1 → bubble_ex=stall_if=stall_id=1 for exactly 1 cycle; hz_cnt=1.
2. $0 immunity: same as test 1 but ex_wbsel=0, id_rs=0 → all stall outputs 0.
3. Branch after load: lw writes $9, beq reads $9. Cycle 1 in EX (H1), cycle 2 in MEM (H3) → bubble_ex high 2 cycles, then 0; hz_cnt=2.
4. Memory wait: mem_req=1, mem_ready=0 for 5 cycles, then 1 → freeze=1 for 5 cycles, bubble_ex=0 throughout even with concurrent H1; frz_cnt=5; state back to IDLE.
5. Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_err rises after 4 frozen cycles and freeze stays 1. Dropping rstn asynchronously clears mem_err, freeze and counters with no clock edge.
6. Counter behaviour: preload hz_cnt to all-ones → holds at all-ones under further stalls; perf_clr together with a stall → hz_cnt=0 next cycle.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared definitions for the pipeline interlock logic.
//   mem_state_e     - data-memory wait FSM states
//   MEM_TIMEOUT_DEF - default frozen-cycle budget before mem_err
//   WAIT_CNT_W      - width of the memory wait counter
//   reg_match()     - true when the ID instruction reads register r (never $0)
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    STALL_IDLE = 2'd0,
    STALL_WAIT = 2'd1,
    STALL_ERR  = 2'd2
  } mem_state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned WAIT_CNT_W      = 16;

  // $0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (r != 5'd0) && ((use_rs && (rs == r)) || (use_rt && (rt == r)));
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: pipeline-side view of the interlock scheduler.
//   ID fields  : id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch
//   EX fields  : ex_rfwr, ex_wbsel, ex_is_load
//   MEM fields : mem_rfwr, mem_wbsel, mem_is_load, mem_req, mem_ready
//   Controls   : stall_if, stall_id, bubble_ex, freeze
// master = pipeline datapath, slave = stall_ctrl.
interface stall_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_is_branch;
  logic       ex_rfwr;
  logic [4:0] ex_wbsel;
  logic       ex_is_load;
  logic       mem_rfwr;
  logic [4:0] mem_wbsel;
  logic       mem_is_load;
  logic       mem_req;
  logic       mem_ready;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       freeze;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
    output ex_rfwr, ex_wbsel, ex_is_load,
    output mem_rfwr, mem_wbsel, mem_is_load, mem_req, mem_ready,
    input  stall_if, stall_id, bubble_ex, freeze
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
    input  ex_rfwr, ex_wbsel, ex_is_load,
    input  mem_rfwr, mem_wbsel, mem_is_load, mem_req, mem_ready,
    output stall_if, stall_id, bubble_ex, freeze
  );
endinterface

// File: rtl/stall_ctrl_mem_wait_fsm.sv
// mem_wait_fsm: tracks slow data-memory accesses.
//   clk, rstn  - clock, asynchronous active-low reset
//   mem_req    - data memory access active this cycle
//   mem_ready  - data memory completes this cycle
//   freeze_req - freeze the whole pipe (combinational, same cycle as the stall)
//   mem_err    - sticky timeout flag, cleared only by reset
module mem_wait_fsm
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic mem_req,
  input  logic mem_ready,
  output logic freeze_req,
  output logic mem_err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  mem_state_e            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_inc;

  assign wait_cnt_inc = wait_cnt + WAIT_CNT_W'(1);

  // The cycle that starts a slow access is already frozen while still in IDLE,
  // so ERR is entered on the edge where the counter steps onto WAIT_LIMIT:
  // that edge closes exactly MEM_TIMEOUT consecutive frozen cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= STALL_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        STALL_IDLE: begin
          wait_cnt <= '0;
          if (mem_req && !mem_ready) state <= STALL_WAIT;
        end
        STALL_WAIT: begin
          if (mem_ready) begin
            state    <= STALL_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == WAIT_LIMIT) begin
              state   <= STALL_ERR;
              mem_err <= 1'b1;
            end
          end
        end
        STALL_ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state    <= STALL_IDLE;
          wait_cnt <= '0;
          mem_err  <= 1'b0;
        end
      endcase
    end
  end

  // mem_err mirrors state==ERR, so the error case reuses the registered flag.
  assign freeze_req = mem_err || (mem_req && !mem_ready);

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline interlock scheduler for the 5-stage MIPS core.
//   clk, rstn - core clock, asynchronous active-low reset
//   pif       - stall_ctrl_if.slave: ID/EX/MEM hazard fields, memory
//               handshake, and the stall_if/stall_id/bubble_ex/freeze controls
//   perf_clr  - synchronous clear of both performance counters
//   mem_err   - sticky memory-timeout flag
//   hz_cnt    - saturating count of cycles with bubble_ex=1
//   frz_cnt   - saturating count of cycles with freeze=1
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  stall_ctrl_if.slave      pif,
  input  logic             perf_clr,
  output logic             mem_err,
  output logic [CNT_W-1:0] hz_cnt,
  output logic [CNT_W-1:0] frz_cnt
);

  logic match_ex;
  logic match_mem;
  logic h_load_use;
  logic h_br_ex;
  logic h_br_mem;
  logic hazard;
  logic freeze_req;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk       (clk),
    .rstn      (rstn),
    .mem_req   (pif.mem_req),
    .mem_ready (pif.mem_ready),
    .freeze_req(freeze_req),
    .mem_err   (mem_err)
  );

  assign match_ex  = reg_match(pif.ex_wbsel, pif.id_rs, pif.id_rt,
                               pif.id_use_rs, pif.id_use_rt);
  assign match_mem = reg_match(pif.mem_wbsel, pif.id_rs, pif.id_rt,
                               pif.id_use_rs, pif.id_use_rt);

  // A branch waiting on a load sees h_load_use/h_br_ex while the load is in
  // EX and h_br_mem once it reaches MEM, giving two bubbles with no state.
  assign h_load_use = pif.ex_is_load && pif.ex_rfwr && match_ex;
  assign h_br_ex    = pif.id_is_branch && pif.ex_rfwr && match_ex;
  assign h_br_mem   = pif.id_is_branch && pif.mem_is_load && pif.mem_rfwr && match_mem;
  assign hazard     = h_load_use || h_br_ex || h_br_mem;

  // Freeze holds EX too, so a bubble then would drop the frozen instruction;
  // any hazard is simply re-evaluated once the freeze lifts.
  always_comb begin
    pif.stall_if  = 1'b0;
    pif.stall_id  = 1'b0;
    pif.bubble_ex = 1'b0;
    pif.freeze    = 1'b0;
    if (rstn) begin
      if (freeze_req) begin
        pif.freeze   = 1'b1;
        pif.stall_if = 1'b1;
        pif.stall_id = 1'b1;
      end else begin
        pif.stall_if  = hazard;
        pif.stall_id  = hazard;
        pif.bubble_ex = hazard;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hz_cnt  <= '0;
      frz_cnt <= '0;
    end else if (perf_clr) begin
      hz_cnt  <= '0;
      frz_cnt <= '0;
    end else begin
      if (pif.bubble_ex && (hz_cnt != '1)) hz_cnt  <= hz_cnt + CNT_W'(1);
      if (pif.freeze && (frz_cnt != '1))   frz_cnt <= frz_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

  localparam int unsigned CW   = 4;
  localparam int unsigned TA   = 64;
  localparam int unsigned TB   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          perf_clr_a, perf_clr_b;
  logic          mem_err_a, mem_err_b;
  logic [CW-1:0] hz_a, frz_a, hz_b, frz_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stall_ctrl_if ia();
  stall_ctrl_if ib();

  stall_ctrl #(.MEM_TIMEOUT(TA), .CNT_W(CW)) dut_a (
    .clk(clk), .rstn(rstn), .pif(ia), .perf_clr(perf_clr_a),
    .mem_err(mem_err_a), .hz_cnt(hz_a), .frz_cnt(frz_a)
  );

  stall_ctrl #(.MEM_TIMEOUT(TB), .CNT_W(CW)) dut_b (
    .clk(clk), .rstn(rstn), .pif(ib), .perf_clr(perf_clr_b),
    .mem_err(mem_err_b), .hz_cnt(hz_b), .frz_cnt(frz_b)
  );

  // Reference model for instance A: frozen-cycle streak, sticky error, counters.
  int unsigned m_hz, m_frz, m_streak;
  bit          m_err;
  bit          exp_stall, exp_bub, exp_frz;
  logic        obs_si, obs_sd, obs_bub, obs_frz, obs_frz_b;

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((ia.id_use_rs && ia.id_rs == r) || (ia.id_use_rt && ia.id_rt == r));
  endfunction

  task automatic model_reset();
    m_hz = 0; m_frz = 0; m_streak = 0; m_err = 0;
  endtask

  task automatic idle_a();
    ia.id_rs = 0; ia.id_rt = 0; ia.id_use_rs = 0; ia.id_use_rt = 0; ia.id_is_branch = 0;
    ia.ex_rfwr = 0; ia.ex_wbsel = 0; ia.ex_is_load = 0;
    ia.mem_rfwr = 0; ia.mem_wbsel = 0; ia.mem_is_load = 0; ia.mem_req = 0; ia.mem_ready = 0;
  endtask

  task automatic idle_b();
    ib.id_rs = 0; ib.id_rt = 0; ib.id_use_rs = 0; ib.id_use_rt = 0; ib.id_is_branch = 0;
    ib.ex_rfwr = 0; ib.ex_wbsel = 0; ib.ex_is_load = 0;
    ib.mem_rfwr = 0; ib.mem_wbsel = 0; ib.mem_is_load = 0; ib.mem_req = 0; ib.mem_ready = 0;
  endtask

  // One clock: sample combinational outputs at negedge, advance the model at posedge.
  task automatic cycle_a();
    bit hz, fr;
    @(negedge clk);
    hz = (ia.ex_rfwr && reads(ia.ex_wbsel) && (ia.ex_is_load || ia.id_is_branch)) ||
         (ia.id_is_branch && ia.mem_is_load && ia.mem_rfwr && reads(ia.mem_wbsel));
    fr = m_err || (ia.mem_req && !ia.mem_ready);
    exp_frz   = rstn && fr;
    exp_stall = rstn && (fr || hz);
    exp_bub   = rstn && !fr && hz;
    obs_si = ia.stall_if; obs_sd = ia.stall_id; obs_bub = ia.bubble_ex;
    obs_frz = ia.freeze; obs_frz_b = ib.freeze;
    @(posedge clk);
    if (rstn) begin
      if (perf_clr_a) begin
        m_hz = 0; m_frz = 0;
      end else begin
        if (exp_bub && m_hz < CMAX) m_hz++;
        if (exp_frz && m_frz < CMAX) m_frz++;
      end
      if (!m_err) begin
        if (ia.mem_req && !ia.mem_ready) begin
          m_streak++;
          if (m_streak >= TA) m_err = 1;
        end else begin
          m_streak = 0;
        end
      end
    end
    #1;
  endtask

  task automatic clear_counters();
    perf_clr_a = 1; perf_clr_b = 1;
    cycle_a();
    perf_clr_a = 0; perf_clr_b = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_a(); idle_b();
    ia.ex_is_load = 1; ia.ex_rfwr = 1; ia.ex_wbsel = 5; ia.id_rs = 5; ia.id_use_rs = 1;
    ib.mem_req = 1;
    #3;
    total++; if (ia.bubble_ex !== 1'b0) begin bad++; $display("FAIL rst_bubble: got %b want 0", ia.bubble_ex); end
    total++; if (ia.stall_if !== 1'b0 || ia.stall_id !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b%b want 00", ia.stall_if, ia.stall_id); end
    total++; if (ib.freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze: got %b want 0", ib.freeze); end
    total++; if (hz_a !== '0 || frz_a !== '0) begin bad++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", hz_a, frz_a); end
    total++; if (mem_err_a !== 1'b0 || mem_err_b !== 1'b0) begin bad++; $display("FAIL rst_err: got %b%b want 00", mem_err_a, mem_err_b); end
    idle_a(); idle_b();
    perf_clr_a = 0; perf_clr_b = 0;
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_load_use();
    clear_counters();
    ia.ex_is_load = 1; ia.ex_rfwr = 1; ia.ex_wbsel = 8; ia.id_rs = 8; ia.id_use_rs = 1;
    cycle_a();
    total++; if (obs_bub !== 1'b1 || obs_bub !== exp_bub) begin bad++; $display("FAIL lu_bubble: got %b want 1", obs_bub); end
    total++; if (obs_si !== 1'b1 || obs_sd !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b%b want 11", obs_si, obs_sd); end
    idle_a();
    cycle_a();
    total++; if (obs_bub !== 1'b0 || obs_si !== 1'b0) begin bad++; $display("FAIL lu_release: got %b%b want 00", obs_bub, obs_si); end
    total++; if (hz_a !== 4'd1) begin bad++; $display("FAIL lu_hzcnt: got %0d want 1", hz_a); end
  endtask

  task automatic test_zero_reg();
    ia.ex_is_load = 1; ia.ex_rfwr = 1; ia.ex_wbsel = 0; ia.id_rs = 0; ia.id_use_rs = 1;
    ia.id_is_branch = 1; ia.mem_is_load = 1; ia.mem_rfwr = 1; ia.mem_wbsel = 0;
    cycle_a();
    total++; if ({obs_bub, obs_si, obs_sd, obs_frz} !== 4'b0000) begin bad++; $display("FAIL zero_reg: got %b want 0000", {obs_bub, obs_si, obs_sd, obs_frz}); end
    total++; if (hz_a !== 4'd1) begin bad++; $display("FAIL zero_hzcnt: got %0d want 1", hz_a); end
    idle_a();
  endtask

  task automatic test_branch_after_load();
    clear_counters();
    ia.ex_is_load = 1; ia.ex_rfwr = 1; ia.ex_wbsel = 9;
    ia.id_is_branch = 1; ia.id_rt = 9; ia.id_use_rt = 1;
    cycle_a();
    total++; if (obs_bub !== 1'b1 || obs_bub !== exp_bub) begin bad++; $display("FAIL bl_cyc1: got %b want 1", obs_bub); end
    ia.ex_is_load = 0; ia.ex_rfwr = 0; ia.ex_wbsel = 0;
    ia.mem_is_load = 1; ia.mem_rfwr = 1; ia.mem_wbsel = 9;
    cycle_a();
    total++; if (obs_bub !== 1'b1 || obs_si !== 1'b1) begin bad++; $display("FAIL bl_cyc2: got %b%b want 11", obs_bub, obs_si); end
    ia.mem_is_load = 0; ia.mem_rfwr = 0; ia.mem_wbsel = 0;
    cycle_a();
    total++; if (obs_bub !== 1'b0) begin bad++; $display("FAIL bl_cyc3: got %b want 0", obs_bub); end
    total++; if (hz_a !== 4'd2) begin bad++; $display("FAIL bl_hzcnt: got %0d want 2", hz_a); end
    idle_a();
  endtask

  task automatic test_mem_wait();
    clear_counters();
    ia.ex_is_load = 1; ia.ex_rfwr = 1; ia.ex_wbsel = 3; ia.id_rs = 3; ia.id_use_rs = 1;
    ia.mem_req = 1; ia.mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle_a();
      total++; if (obs_frz !== 1'b1 || obs_bub !== 1'b0 || obs_si !== 1'b1) begin
        bad++; $display("FAIL mw_frozen[%0d]: got frz=%b bub=%b si=%b want 1 0 1", i, obs_frz, obs_bub, obs_si); end
    end
    ia.mem_ready = 1;
    cycle_a();
    total++; if (obs_frz !== 1'b0 || obs_bub !== 1'b1) begin bad++; $display("FAIL mw_done: got frz=%b bub=%b want 0 1", obs_frz, obs_bub); end
    total++; if (frz_a !== 4'd5 || hz_a !== 4'd1) begin bad++; $display("FAIL mw_cnt: got frz=%0d hz=%0d want 5 1", frz_a, hz_a); end
    idle_a();
    ia.mem_req = 1; ia.mem_ready = 1;
    cycle_a();
    total++; if (obs_frz !== 1'b0 || mem_err_a !== 1'b0) begin bad++; $display("FAIL mw_idle_hit: got frz=%b err=%b want 0 0", obs_frz, mem_err_a); end
    idle_a();
  endtask

  task automatic test_counters();
    clear_counters();
    ia.ex_is_load = 1; ia.ex_rfwr = 1; ia.ex_wbsel = 17; ia.id_rt = 17; ia.id_use_rt = 1;
    for (int i = 0; i < 18; i++) cycle_a();
    total++; if (hz_a !== 4'd15 || hz_a !== m_hz[CW-1:0]) begin bad++; $display("FAIL cnt_sat: got %0d want 15", hz_a); end
    perf_clr_a = 1;
    cycle_a();
    perf_clr_a = 0;
    total++; if (obs_bub !== 1'b1 || hz_a !== 4'd0) begin bad++; $display("FAIL cnt_clr: got bub=%b hz=%0d want 1 0", obs_bub, hz_a); end
    cycle_a();
    total++; if (hz_a !== 4'd1) begin bad++; $display("FAIL cnt_after_clr: got %0d want 1", hz_a); end
    idle_a();
  endtask

  task automatic test_timeout();
    clear_counters();
    ib.mem_req = 1; ib.mem_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle_a();
      total++; if (obs_frz_b !== 1'b1) begin bad++; $display("FAIL to_freeze[%0d]: got %b want 1", k, obs_frz_b); end
      total++; if (mem_err_b !== (k >= TB)) begin bad++; $display("FAIL to_err[%0d]: got %b want %b", k, mem_err_b, k >= TB); end
    end
    ib.mem_ready = 1;
    cycle_a();
    total++; if (obs_frz_b !== 1'b1 || frz_b !== 4'd9) begin bad++; $display("FAIL to_sticky: got frz=%b cnt=%0d want 1 9", obs_frz_b, frz_b); end
    ib.mem_ready = 0;
    #2 rstn = 0;
    #1;
    total++; if (mem_err_b !== 1'b0 || ib.freeze !== 1'b0) begin bad++; $display("FAIL to_async_rst: got err=%b frz=%b want 0 0", mem_err_b, ib.freeze); end
    total++; if (frz_b !== '0 || hz_b !== '0 || hz_a !== '0) begin bad++; $display("FAIL to_rst_cnt: got %0d/%0d/%0d want 0", frz_b, hz_b, hz_a); end
    model_reset();
    idle_b();
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit pend = 0;
    clear_counters();
    for (int i = 0; i < 400; i++) begin
      ia.id_rs = 5'($urandom_range(0, 3)); ia.id_rt = 5'($urandom_range(0, 3));
      ia.id_use_rs = 1'($urandom); ia.id_use_rt = 1'($urandom);
      ia.id_is_branch = ($urandom_range(0, 2) == 0);
      ia.ex_rfwr = 1'($urandom); ia.ex_wbsel = 5'($urandom_range(0, 3)); ia.ex_is_load = 1'($urandom);
      ia.mem_rfwr = 1'($urandom); ia.mem_wbsel = 5'($urandom_range(0, 3)); ia.mem_is_load = 1'($urandom);
      ia.mem_req = pend ? 1'b1 : ($urandom_range(0, 2) == 0);
      ia.mem_ready = ($urandom_range(0, 3) == 0);
      perf_clr_a = ($urandom_range(0, 15) == 0);
      pend = ia.mem_req && !ia.mem_ready;
      cycle_a();
      total++; if (obs_bub !== exp_bub || obs_frz !== exp_frz) begin
        bad++; $display("FAIL rnd_ctl[%0d]: got bub=%b frz=%b want %b %b", i, obs_bub, obs_frz, exp_bub, exp_frz); end
      total++; if (obs_si !== exp_stall || obs_sd !== exp_stall) begin
        bad++; $display("FAIL rnd_stall[%0d]: got %b%b want %b", i, obs_si, obs_sd, exp_stall); end
      total++; if (hz_a !== m_hz[CW-1:0] || frz_a !== m_frz[CW-1:0] || mem_err_a !== m_err) begin
        bad++; $display("FAIL rnd_state[%0d]: got hz=%0d frz=%0d err=%b want %0d %0d %b", i, hz_a, frz_a, mem_err_a, m_hz, m_frz, m_err); end
    end
    perf_clr_a = 0;
    idle_a();
  endtask

  initial begin
    rstn = 0;
    perf_clr_a = 0; perf_clr_b = 0;
    model_reset();
    idle_a(); idle_b();
    #12;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_after_load();
    test_mem_wait();
    test_counters();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
